// File: rtl/seg_bus_reader.sv
// seg_bus_reader
//   Watches a multiplexed 7-segment bus and recovers the 4-bit value shown
//   on each digit position. A sample must stay unchanged for STABLE_CYCLES
//   consecutive clocks before it is captured, and it is captured only once
//   per dwell. This keeps anode switching transients and ghosting from
//   corrupting the recovered values.
//
// Ports
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   an_i           anode enables, active-low, bit n selects digit n
//   hex_i          segments, active-low, bit0 = a ... bit6 = g
//   digits_o       recovered values, nibble n belongs to digit n
//   digit_valid_o  digit n has had a good capture since reset (sticky)
//   err_o          last capture attempt on digit n held an unknown pattern
//   frame_done_o   one-cycle pulse once every position has been captured
//                  since the previous pulse
//
// Timing: the first edge that samples a stable input is edge 0. The counter
// reaches STABLE_CYCLES at edge STABLE_CYCLES, and the outputs update at
// edge STABLE_CYCLES+1.

module seg_bus_reader #(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DIGITS-1:0]     an_i,
  input  logic [6:0]            hex_i,
  output logic [4*DIGITS-1:0]   digits_o,
  output logic [DIGITS-1:0]     digit_valid_o,
  output logic [DIGITS-1:0]     err_o,
  output logic                  frame_done_o
);

  localparam logic [15:0] STABLE = 16'(STABLE_CYCLES);

  // s_* is the current registered sample. p_* is the sample before it. The
  // dwell counter always describes the sample held in p_*.
  logic [DIGITS-1:0] s_an, p_an;
  logic [6:0]        s_hex, p_hex;

  logic [15:0]       run_cnt, run_cnt_next;
  logic              captured, captured_next;
  logic [DIGITS-1:0] seen, seen_set, cap_mask;
  logic              qualifying, same_sample, capture;
  logic              recognised;
  logic [3:0]        value;

  // Returns {recognised, value}.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h7F:   r = {1'b1, 4'hF};  // blank digit
      default: r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  always_comb begin
    qualifying    = ($countones(~s_an) == 1);
    same_sample   = (s_an == p_an) && (s_hex == p_hex);
    capture       = (run_cnt == STABLE) && !captured;
    run_cnt_next  = run_cnt;
    captured_next = captured | capture;

    if (!qualifying) begin
      run_cnt_next  = 16'd0;
      captured_next = 1'b0;
    end else if (!same_sample) begin
      // A new dwell starts. Clearing the flag here takes priority over a
      // capture of the previous dwell in the same cycle.
      run_cnt_next  = 16'd1;
      captured_next = 1'b0;
    end else if (run_cnt != STABLE) begin
      run_cnt_next  = run_cnt + 16'd1;
    end

    {recognised, value} = decode(p_hex);

    // A capture only occurs with a qualifying p_an, so ~p_an is one-hot.
    cap_mask = capture ? ~p_an : '0;
    seen_set = seen | cap_mask;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s_an          <= '1;
      p_an          <= '1;
      s_hex         <= '1;
      p_hex         <= '1;
      run_cnt       <= 16'd0;
      captured      <= 1'b0;
      seen          <= '0;
      digits_o      <= '0;
      digit_valid_o <= '0;
      err_o         <= '0;
      frame_done_o  <= 1'b0;
    end else begin
      s_an     <= an_i;
      s_hex    <= hex_i;
      p_an     <= s_an;
      p_hex    <= s_hex;
      run_cnt  <= run_cnt_next;
      captured <= captured_next;

      for (int n = 0; n < DIGITS; n++) begin
        if (cap_mask[n]) begin
          if (recognised) begin
            digits_o[4*n +: 4] <= value;
            digit_valid_o[n]   <= 1'b1;
            err_o[n]           <= 1'b0;
          end else begin
            err_o[n]           <= 1'b1;
          end
        end
      end

      // The capture that completes a frame is absorbed by the clear.
      if (&seen_set) begin
        frame_done_o <= 1'b1;
        seen         <= '0;
      end else begin
        frame_done_o <= 1'b0;
        seen         <= seen_set;
      end
    end
  end

endmodule

// File: tb/tb_seg_bus_reader.sv
// tb_seg_bus_reader
//   Self-checking bench for seg_bus_reader. The reference model works on the
//   stream of applied inputs. It measures dwell lengths and schedules each
//   capture two edges after the edge that sampled the STABLE-th identical
//   sample. It then compares all outputs after every clock edge.
//   A second instance with DIGITS=1 and STABLE_CYCLES=1 covers the
//   single-sample capture boundary.

module tb_seg_bus_reader;
  localparam int DIGITS = 4;
  localparam int STABLE = 4;
  localparam int EW     = 41;  // {due edge[31:0], digit[1:0], hex[6:0]}

  logic        clk_i;
  logic        rst_i;
  logic [3:0]  an_i;
  logic [6:0]  hex_i;
  logic [15:0] digits_o;
  logic [3:0]  digit_valid_o, err_o;
  logic        frame_done_o;

  logic [0:0]  an1;
  logic [3:0]  dig1;
  logic [0:0]  val1, err1;
  logic        fd1;

  seg_bus_reader #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .an_i(an_i), .hex_i(hex_i),
    .digits_o(digits_o), .digit_valid_o(digit_valid_o), .err_o(err_o),
    .frame_done_o(frame_done_o)
  );

  seg_bus_reader #(.DIGITS(1), .STABLE_CYCLES(1)) u_s1 (
    .clk_i(clk_i), .rst_i(rst_i), .an_i(an1), .hex_i(hex_i),
    .digits_o(dig1), .digit_valid_o(val1), .err_o(err1),
    .frame_done_o(fd1)
  );

  // ---------------- clock ----------------
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- checking ----------------
  int tests, fails;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic [15:0] m_digits;
  logic [3:0]  m_valid, m_err, m_seen;
  logic        m_frame;
  logic [3:0]  m_last_an;
  logic [6:0]  m_last_hex;
  int          m_run;
  int          edge_no;
  int          pulses;
  logic [EW-1:0] exp_q[$];

  function automatic int m_lookup(input logic [6:0] h);
    for (int i = 0; i < 10; i++) if (seg_tab[i] == h) return i;
    if (h == 7'h7F) return 15;
    return -1;
  endfunction

  task automatic model_reset();
    m_digits = '0; m_valid = '0; m_err = '0; m_seen = '0; m_frame = 1'b0;
    m_last_an = '1; m_last_hex = '1; m_run = 0;
    exp_q.delete();
  endtask

  task automatic model_sample(input logic [3:0] an, input logic [6:0] hex);
    bit qual;
    int d;
    qual = ($countones(~an) == 1);
    if (!qual) m_run = 0;
    else if (m_run > 0 && an == m_last_an && hex == m_last_hex) m_run++;
    else m_run = 1;
    m_last_an  = an;
    m_last_hex = hex;
    if (qual && m_run == STABLE) begin
      d = 0;
      for (int i = 0; i < DIGITS; i++) if (!an[i]) d = i;
      exp_q.push_back({32'(edge_no + 2), 2'(d), hex});
    end
  endtask

  task automatic model_apply();
    logic [EW-1:0] e;
    int d, v;
    m_frame = 1'b0;
    while (exp_q.size() > 0 && exp_q[0][40:9] == 32'(edge_no)) begin
      e = exp_q.pop_front();
      d = int'(e[8:7]);
      v = m_lookup(e[6:0]);
      if (v >= 0) begin
        m_digits[4*d +: 4] = 4'(v);
        m_valid[d] = 1'b1;
        m_err[d]   = 1'b0;
      end else begin
        m_err[d]   = 1'b1;
      end
      m_seen[d] = 1'b1;
      if (&m_seen) begin
        m_frame = 1'b1;
        m_seen  = '0;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic [3:0] an, input logic [6:0] hex);
    an_i  = an;
    hex_i = hex;
    @(posedge clk_i);
    edge_no++;
    model_sample(an, hex);
    model_apply();
    #1;
    check("digits", 32'(digits_o), 32'(m_digits));
    check("valid", 32'(digit_valid_o), 32'(m_valid));
    check("err", 32'(err_o), 32'(m_err));
    check("frame", 32'(frame_done_o), 32'(m_frame));
    if (frame_done_o) pulses++;
  endtask

  task automatic dwell(input int d, input logic [6:0] hex, input int len);
    for (int i = 0; i < len; i++) cycle(~(4'b0001 << d), hex);
  endtask

  task automatic gap(input int len);
    for (int i = 0; i < len; i++) cycle(4'hF, 7'h7F);
  endtask

  // ---------------- stimulus ----------------
  int lat;
  logic [23:0] snap;
  logic [3:0]  ran;
  logic [6:0]  rhex;
  int          k;

  initial begin
    tests = 0; fails = 0; edge_no = 0; pulses = 0;
    an_i = '1; hex_i = '1; an1 = 1'b1;
    rst_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_digits", 32'(digits_o), 32'h0);
    check("rst_valid", 32'(digit_valid_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_frame", 32'(frame_done_o), 32'h0);
    check("rst_s1_valid", 32'(val1), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Capture latency of a fresh dwell, and a single capture per long dwell.
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      cycle(4'b1110, 7'h24);
      if (lat < 0 && digit_valid_o[0]) lat = i;
    end
    check("t1_latency", 32'(lat), 32'(STABLE + 2));
    check("t1_nibble0", 32'(digits_o[3:0]), 32'h2);

    // A dwell that is too short is never captured. The switch starts a fresh dwell.
    gap(2);
    dwell(1, 7'h24, STABLE - 1);
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      cycle(4'b1101, 7'h30);
      check("t2_no_two", 32'(digits_o[7:4] == 4'h2), 32'h0);
      if (lat < 0 && digits_o[7:4] == 4'h3) lat = i;
    end
    check("t2_latency", 32'(lat), 32'(STABLE + 2));

    // Two full scans, each giving exactly one frame pulse.
    for (int rep = 0; rep < 2; rep++) begin
      pulses = 0;
      dwell(0, 7'h79, 6); gap(2);
      dwell(1, 7'h40, 6); gap(2);
      dwell(2, 7'h19, 6); gap(2);
      dwell(3, 7'h7F, 6); gap(2);
      check("t3_pulses", 32'(pulses), 32'h1);
      check("t3_digits", 32'(digits_o), 32'hF401);
      check("t3_valid", 32'(digit_valid_o), 32'hF);
    end

    // Two anodes low never qualifies.
    snap = {digits_o, digit_valid_o, err_o};
    pulses = 0;
    for (int i = 0; i < 10; i++) cycle(4'b1100, 7'h40);
    check("t4_unchanged", 32'({digits_o, digit_valid_o, err_o}), 32'(snap));
    check("t4_pulses", 32'(pulses), 32'h0);

    // An unknown pattern sets err but keeps the old value. A good capture clears err.
    dwell(2, 7'h12, 6); gap(2);
    dwell(2, 7'h7E, 6); gap(2);
    check("t5_err_set", 32'(err_o[2]), 32'h1);
    check("t5_keep5", 32'(digits_o[11:8]), 32'h5);
    check("t5_valid_kept", 32'(digit_valid_o[2]), 32'h1);
    dwell(2, 7'h02, 6); gap(2);
    check("t5_six", 32'(digits_o[11:8]), 32'h6);
    check("t5_err_clr", 32'(err_o[2]), 32'h0);

    // Asynchronous reset in the middle of a dwell, then the full latency again.
    dwell(3, 7'h19, 4);
    #2;
    rst_i = 1'b1;
    #1;
    check("t6_async_digits", 32'(digits_o), 32'h0);
    check("t6_async_valid", 32'(digit_valid_o), 32'h0);
    check("t6_async_err", 32'(err_o), 32'h0);
    check("t6_async_frame", 32'(frame_done_o), 32'h0);
    model_reset();
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      cycle(4'b0111, 7'h10);
      if (lat < 0 && digit_valid_o[3]) lat = i;
    end
    check("t6_latency", 32'(lat), 32'(STABLE + 2));
    check("t6_nibble3", 32'(digits_o[15:12]), 32'h9);

    // STABLE_CYCLES=1: a single qualifying sample is captured two edges later.
    an1 = 1'b0;
    cycle(4'hF, 7'h79);
    an1 = 1'b1;
    cycle(4'hF, 7'h7F);
    check("s1_not_yet", 32'(val1), 32'h0);
    cycle(4'hF, 7'h7F);
    check("s1_valid", 32'(val1), 32'h1);
    check("s1_digit", 32'(dig1), 32'h1);
    check("s1_frame", 32'(fd1), 32'h1);
    cycle(4'hF, 7'h7F);
    check("s1_frame_low", 32'(fd1), 32'h0);

    // Randomized traffic: dwells of random length, glitches, multi-anode noise.
    for (int it = 0; it < 400; it++) begin
      k = $urandom_range(0, 9);
      if (k < 7) begin
        if ($urandom_range(0, 3) == 0) rhex = 7'($urandom);
        else begin
          k = $urandom_range(0, 10);
          rhex = (k == 10) ? 7'h7F : seg_tab[k];
        end
        dwell($urandom_range(0, DIGITS - 1), rhex, $urandom_range(1, 8));
      end else if (k == 7) begin
        ran = 4'($urandom);
        cycle(ran, 7'($urandom));
      end else begin
        gap($urandom_range(0, 2));
      end
    end
    gap(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
